// File: rtl/event_stat_poller.sv
// rtl/event_stat_poller.sv - periodic Wishbone poller of event statistics counters, streamed as one framed snapshot
// Optional EVENT_STAT_POLLER_DELTA_EN: emit per-counter deltas against the previous snapshot instead of raw values.
module event_stat_poller #(
  parameter logic [12:0] BASE_ADR = 13'h0000,
  parameter int          NUM_REGS = 6,
  parameter int          INTERVAL = 100000000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [12:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic [31:0] stat_tdata,
  output logic [2:0]  stat_tuser,
  output logic        stat_tlast,
  output logic        stat_tvalid,
  input  logic        stat_tready,
  output logic        busy_o,
  output logic [7:0]  err_count_o
);

  localparam int TW = $clog2(INTERVAL);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, GAP, REQ, EMIT} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          req_now, go;
  logic [2:0]    idx_q;
  logic [9:0]    wait_q;
  logic          cyc_q, stb_q;
  logic [12:0]   adr_q;
  logic [31:0]   tdata_q;
  logic [2:0]    tuser_q;
  logic          tlast_q, tvalid_q;
  logic [7:0]    err_cnt_q;
  logic [31:0]   sample_q [NUM_REGS];
  logic          rd_fail, rd_done;
  logic [31:0]   rd_val;
  logic [2:0]    beat_idx;
  logic [31:0]   beat_raw, beat_data;
`ifdef EVENT_STAT_POLLER_DELTA_EN
  logic [31:0]   prev_q [NUM_REGS];
  logic          fail_q [NUM_REGS];
  logic          beat_fail;
`endif

  // Requests arriving while a poll runs stay latched; in IDLE they launch a poll directly.
  always_comb begin
    req_now   = (timer_q == '0) | start_i;
    timer_d   = (timer_q == '0) ? TW'(INTERVAL - 1) : timer_q - TW'(1);
    go        = (state_q == IDLE) && (pending_q || req_now);
    pending_d = (state_q == IDLE) ? 1'b0 : (pending_q | req_now);
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q   <= TW'(INTERVAL - 1);
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign rd_fail = wb_err_i | wb_rty_i | (~wb_ack_i & (wait_q == 10'(TIMEOUT)));
  assign rd_done = wb_ack_i | rd_fail;
  assign rd_val  = rd_fail ? 32'hFFFFFFFF : wb_dat_i;

  // Next beat to load; a single-register poll takes beat 0 straight from the bus.
  always_comb begin
    beat_idx  = (state_q == EMIT) ? idx_q + 3'd1 : 3'd0;
    beat_raw  = (state_q == REQ && idx_q == 3'd0) ? rd_val : sample_q[beat_idx];
`ifdef EVENT_STAT_POLLER_DELTA_EN
    beat_fail = (state_q == REQ && idx_q == 3'd0) ? rd_fail : fail_q[beat_idx];
    beat_data = beat_fail ? 32'hFFFFFFFF : beat_raw - prev_q[beat_idx];
`else
    beat_data = beat_raw;
`endif
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      wait_q    <= 10'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      adr_q     <= 13'd0;
      tdata_q   <= 32'd0;
      tuser_q   <= 3'd0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      err_cnt_q <= 8'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
        sample_q[k] <= 32'd0;
`ifdef EVENT_STAT_POLLER_DELTA_EN
        prev_q[k]   <= 32'd0;
        fail_q[k]   <= 1'b0;
`endif
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            idx_q   <= 3'd0;
            state_q <= GAP;
          end
        end
        GAP: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          adr_q   <= BASE_ADR + 13'd16 + {8'd0, idx_q, 2'b00};
          wait_q  <= 10'd1;
          state_q <= REQ;
        end
        REQ: begin
          if (rd_done) begin
            cyc_q           <= 1'b0;
            stb_q           <= 1'b0;
            sample_q[idx_q] <= rd_val;
`ifdef EVENT_STAT_POLLER_DELTA_EN
            fail_q[idx_q]   <= rd_fail;
`endif
            if (rd_fail && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (idx_q == LAST_IDX) begin
              idx_q    <= 3'd0;
              tvalid_q <= 1'b1;
              tdata_q  <= beat_data;
              tuser_q  <= 3'd0;
              tlast_q  <= (LAST_IDX == 3'd0);
              state_q  <= EMIT;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= GAP;
            end
          end else begin
            wait_q <= wait_q + 10'd1;
          end
        end
        EMIT: begin
          if (stat_tready) begin
`ifdef EVENT_STAT_POLLER_DELTA_EN
            if (!fail_q[idx_q]) prev_q[idx_q] <= sample_q[idx_q];
`endif
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idx_q   <= beat_idx;
              tdata_q <= beat_data;
              tuser_q <= beat_idx;
              tlast_q <= (beat_idx == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = 1'b0;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = 4'hF;
  assign wb_dat_o    = 32'd0;
  assign stat_tdata  = tdata_q;
  assign stat_tuser  = tuser_q;
  assign stat_tlast  = tlast_q;
  assign stat_tvalid = tvalid_q;
  assign busy_o      = (state_q != IDLE);
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_event_stat_poller.sv
// tb/tb_event_stat_poller.sv - self-checking bench for event_stat_poller with a target model and snapshot scoreboard
module tb_event_stat_poller;
  localparam int NREG = 6;
  localparam int INTV = 100;
  localparam int TMO  = 8;
`ifdef EVENT_STAT_POLLER_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i, start_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [12:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0] stat_tdata;
  logic [2:0]  stat_tuser;
  logic        stat_tlast, stat_tvalid, stat_tready;
  logic        busy_o;
  logic [7:0]  err_count_o;

  always #5 clk = ~clk;

  event_stat_poller #(.BASE_ADR(13'h0000), .NUM_REGS(NREG), .INTERVAL(INTV), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .stat_tdata(stat_tdata), .stat_tuser(stat_tuser), .stat_tlast(stat_tlast),
    .stat_tvalid(stat_tvalid), .stat_tready(stat_tready),
    .busy_o(busy_o), .err_count_o(err_count_o)
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] raw;
    logic        fail;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cycles = 0;
  int          mode = 0;       // 0 ack, 1 never ack, 2 ack+err on counter 2, 3 rty on counter 4
  int          stb_cnt, rd_idx, err_m;
  int          polls_done = 0;
  int          busy_rises = 0;
  logic        busy_prev, stall_prev, pend_fail;
  logic [31:0] pend_raw, p_tdata;
  logic [2:0]  p_tuser;
  logic        p_tlast;
  logic [31:0] cnt      [NREG];
  logic [31:0] prev_m   [NREG];
  logic [31:0] act_data [NREG];
  logic [12:0] addr_log [NREG];
  exp_t        exp_q[$];
  exp_t        head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_val(input exp_t e);
    if (e.fail) return 32'hFFFFFFFF;
    if (DELTA) return e.raw - prev_m[e.idx];
    return e.raw;
  endfunction

  // Target model plus stream scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n_i) begin
      exp_q.delete();
      stb_cnt = 0; rd_idx = 0; err_m = 0;
      busy_prev = 1'b0; stall_prev = 1'b0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'd0;
      for (int k = 0; k < NREG; k++) prev_m[k] = 32'd0;
    end else begin
      chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
      if (!wb_stb_o && stb_cnt > 0) begin
        chk("stb_len", stb_cnt, (mode == 1) ? TMO : 2);
        exp_q.push_back('{idx: 3'(rd_idx), raw: pend_raw, fail: pend_fail});
        if (pend_fail) err_m++;
        rd_idx  = (rd_idx + 1) % NREG;
        stb_cnt = 0;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wb_stb_o) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          chk("adr", wb_adr_o, 13'(16 + 4 * rd_idx));
          addr_log[rd_idx] = wb_adr_o;
          chk("we", wb_we_o, 1'b0);
          chk("sel", wb_sel_o, 4'hF);
          chk("dat_o", wb_dat_o, 32'd0);
          pend_raw  = 32'hFFFFFFFF;
          pend_fail = 1'b1;
        end
        if (stb_cnt == 2 && mode != 1) begin
          wb_ack_i  = 1'b1;
          wb_dat_i  = cnt[rd_idx];
          pend_raw  = cnt[rd_idx];
          pend_fail = 1'b0;
          if (mode == 2 && rd_idx == 2) begin
            wb_err_i = 1'b1; pend_raw = 32'hFFFFFFFF; pend_fail = 1'b1;
          end
          if (mode == 3 && rd_idx == 4) begin
            wb_ack_i = 1'b0; wb_rty_i = 1'b1; pend_raw = 32'hFFFFFFFF; pend_fail = 1'b1;
          end
        end
      end
      if (stall_prev) begin
        chk("hold_valid", stat_tvalid, 1'b1);
        chk("hold_data", stat_tdata, p_tdata);
        chk("hold_user", stat_tuser, p_tuser);
        chk("hold_last", stat_tlast, p_tlast);
      end
      if (stat_tvalid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_unexpected: got beat tuser %0d, required no beat", stat_tuser);
        end else begin
          head = exp_q[0];
          chk("tuser", stat_tuser, head.idx);
          chk("tlast", stat_tlast, head.idx == 3'(NREG - 1));
          chk("tdata", stat_tdata, exp_val(head));
          if (stat_tready) begin
            act_data[head.idx] = stat_tdata;
            if (DELTA && !head.fail) prev_m[head.idx] = head.raw;
            void'(exp_q.pop_front());
            if (head.idx == 3'(NREG - 1)) polls_done++;
          end
        end
      end
      stall_prev = stat_tvalid && !stat_tready;
      p_tdata = stat_tdata; p_tuser = stat_tuser; p_tlast = stat_tlast;
      chk("err_count", err_count_o, (err_m > 255) ? 255 : err_m);
      if (busy_o && !busy_prev) busy_rises++;
      busy_prev = busy_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) tick();
    rst_n_i = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_poll(input int bound);
    int p0 = polls_done;
    int n = 0;
    while (polls_done == p0 && n < bound) begin
      tick();
      n++;
    end
    if (polls_done == p0) begin
      tests++; fails++;
      $display("FAIL poll_timeout: got no snapshot in %0d cycles, required one", bound);
    end
  endtask

  task automatic wait_busy(input int bound, output int n);
    n = 0;
    while (!busy_o && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, r1, r2, c0, br0;
    rst_n_i = 1'b0; start_i = 1'b0; stat_tready = 1'b1;
    for (int k = 0; k < NREG; k++) cnt[k] = 32'(10 + k);
    repeat (3) tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_adr", wb_adr_o, 13'd0);
    chk("rst_tvalid", stat_tvalid, 1'b0);
    chk("rst_tdata", stat_tdata, 32'd0);
    chk("rst_tlast", stat_tlast, 1'b0);
    chk("rst_err", err_count_o, 8'd0);
    rst_n_i = 1'b1;

    // Interval-only polling: first poll 100 cycles after reset, then every 100.
    wait_busy(300, n);
    chk("first_interval", n, 100);
    r1 = cycles;
    wait_poll(200);
    chk("beat0", act_data[0], 32'd10);
    chk("beat3", act_data[3], 32'd13);
    chk("beat5", act_data[5], 32'd15);
    chk("adr0", addr_log[0], 13'h010);
    chk("adr5", addr_log[5], 13'h024);
    wait_busy(300, n);
    r2 = cycles;
    chk("interval_period", r2 - r1, 100);
    wait_poll(200);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1'b1);
    wait_poll(200);
    chk("start_beat1", act_data[1], DELTA ? 32'd0 : 32'd11);

    // Counter wrap between polls.
    do_reset();
    cnt[0] = 32'hFFFFFFF0;
    pulse_start();
    wait_poll(200);
    chk("wrap_first", act_data[0], 32'hFFFFFFF0);
    cnt[0] = 32'h00000010;
    pulse_start();
    wait_poll(200);
    chk("wrap_second", act_data[0], DELTA ? 32'h00000020 : 32'h00000010);
    chk("wrap_beat1", act_data[1], DELTA ? 32'd0 : 32'd11);
    cnt[0] = 32'd10;

    // Silent target: every read times out.
    do_reset();
    mode = 1;
    pulse_start();
    wait_poll(400);
    chk("timeout_err6", err_count_o, 8'd6);
    chk("timeout_data", act_data[3], 32'hFFFFFFFF);
    for (int k = 1; k < 50; k++) wait_poll(400);
    chk("err_saturate", err_count_o, 8'd255);
    do_reset();
    mode = 2;
    pulse_start();
    wait_poll(200);
    chk("errack_data", act_data[2], 32'hFFFFFFFF);
    chk("errack_neighbor", act_data[1], 32'd11);
    chk("errack_count", err_count_o, 8'd1);
    mode = 3;
    pulse_start();
    wait_poll(200);
    chk("rty_data", act_data[4], 32'hFFFFFFFF);
    chk("after_fail", act_data[2], 32'd12);
    chk("rty_count", err_count_o, 8'd2);
    mode = 0;

    // Downstream stall spanning an interval expiry and start pulses.
    do_reset();
    c0 = cycles;
    br0 = busy_rises;
    repeat (70) tick();
    pulse_start();
    n = 0;
    while (!stat_tvalid && n < 100) begin
      tick();
      n++;
    end
    stat_tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      start_i = (k == 3 || k == 8 || k == 13);
      tick();
    end
    start_i = 1'b0;
    chk("stall_valid", stat_tvalid, 1'b1);
    chk("stall_user", stat_tuser, 3'd0);
    stat_tready = 1'b1;
    wait_poll(100);
    wait_poll(100);
    while (cycles - c0 < 190) tick();
    chk("coalesced_polls", busy_rises - br0, 2);

    // Asynchronous reset in the middle of a read.
    pulse_start();
    n = 0;
    while (!(wb_stb_o && rd_idx == 3) && n < 100) begin
      tick();
      n++;
    end
    @(negedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_tvalid", stat_tvalid, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    tick();
    tick();
    rst_n_i = 1'b1;
    pulse_start();
    wait_poll(200);
    chk("restart_adr", addr_log[0], 13'h010);
    chk("restart_beat0", act_data[0], 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/event_stat_poller.md
# event_stat_poller

Wishbone initiator that periodically reads the event-path statistics counters (per-link Aurora dword counts, Ethernet qword and event counts) from the event register block. It forms one snapshot per poll and streams it to the housekeeping path as a framed AXI4-Stream burst. It sits in the wb_clk_i domain between the event register target and the housekeeping packetizer.

## Interface
- `BASE_ADR`, 13'h0000: byte base address of the event register block.
- `NUM_REGS`, 6: counters read per poll, 1–8. Word offsets are 4..4+NUM_REGS-1: dwords[0..3], qwords, events.
- `INTERVAL`, 100000000: poll period in wb_clk_i cycles, ≥ 2.
- `TIMEOUT`, 255: maximum cycles to wait for ack per read, 1–1023.
- `wb_clk_i`  in  1  sole clock.
- `rst_n_i`  in  1  reset; asynchronous and active-low.
- `start_i`  in  1  one-cycle request for an immediate poll.
- `wb_cyc_o`  out  1  bus cycle.
- `wb_stb_o`  out  1  strobe.
- `wb_we_o`  out  1  tied 0 (read-only initiator).
- `wb_adr_o`  out  13  byte address, BASE_ADR + 4·(4+i).
- `wb_sel_o`  out  4  tied 4'hF.
- `wb_dat_o`  out  32  tied 0.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`  in  1  ack.
- `wb_err_i`  in  1  bus error.
- `wb_rty_i`  in  1  retry; treated as error.
- `stat_tdata`  out  32  counter value or delta.
- `stat_tuser`  out  3  counter index i.
- `stat_tlast`  out  1  marks the last beat of a snapshot.
- `stat_tvalid`  out  1  beat valid.
- `stat_tready`  in  1  downstream ready.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_count_o`  out  8  saturating count of failed reads.

## Operation
- Reset (asynchronous, effective immediately) clears the following: FSM → IDLE, all bus and stream outputs 0, timer = INTERVAL-1, pending = 0, err_count = 0, prev[] = 0.
- Interval timer:
  - Free-running down-counter.
  - At 0, it reloads INTERVAL-1 and sets `pending`.
  - `start_i` also sets `pending`.
  - Multiple requests while pending coalesce into one.
- FSM states: IDLE, GAP, REQ, EMIT.
  - IDLE: if pending, clear pending, set i = 0, go to GAP.
  - GAP: one cycle with cyc/stb low, then go to REQ. The target's registered ack must flush before the next strobe.
  - REQ: cyc = stb = 1, adr per i.
    - On ack_i: latch wb_dat_i into sample[i] and drop cyc/stb.
    - On err_i, rty_i, or wait counter reaching TIMEOUT: sample[i] = 32'hFFFFFFFF, err_count += 1 (saturating at 255), drop cyc/stb.
    - Next state: i++ and GAP, or EMIT after the last index.
  - EMIT: stream beats i = 0..NUM_REGS-1.
    - Beat fields: tuser = i, tlast on i = NUM_REGS-1.
    - Advance on tvalid && tready.
    - After the tlast handshake, go to IDLE.
- Ack and error in the same cycle: error wins.
- Pending set during a poll is serviced after return to IDLE.
- Data, user and last hold stable while tvalid && !tready.

## Timing
- Minimum read: GAP 1 cycle, then REQ until ack. The target acks on the 2nd cycle of stb, so 3 cycles per read.
- A 6-register poll takes ≥ 18 cycles before the first beat. First beat valid the cycle after leaving the final REQ.
- stb drops at the clock edge after ack_i is sampled high. Never more than one ack is consumed per strobe.
- Timeout: cyc/stb drop at the edge where the wait count equals TIMEOUT, i.e. after TIMEOUT cycles with stb high.
- Timer reload and start_i are evaluated every cycle, in every state.

## Configuration
- `EVENT_STAT_POLLER_DELTA_EN` defined:
  - stat_tdata = sample[i] − prev[i], modulo 2^32, so counter wrap yields the correct delta.
  - prev[i] updates to sample[i] at the handshake of beat i.
  - First poll after reset emits the raw value (prev = 0).
  - A failed read emits 32'hFFFFFFFF and does not update prev[i].
- Not defined: stat_tdata = sample[i] raw; no prev storage is instantiated.

## Test plan
- Responsive target acking on the 2nd stb cycle, start_i pulse, counters 10..15 → 6 beats, tuser 0..5, data 10..15, tlast on beat 5, adr 0x010..0x024, one idle cycle between strobes.
- DELTA_EN: poll with counter 0 = 32'hFFFFFFF0, then 32'h00000010 → beats 32'hFFFFFFF0, then 32'h00000020.
- Target never acks, TIMEOUT = 8 → each stb lasts exactly 8 cycles, 6 beats of 32'hFFFFFFFF, err_count_o = 6. After 50 such polls err_count_o saturates at 255.
- stat_tready held low 20 cycles during EMIT, with an INTERVAL expiry and 3 start_i pulses meanwhile → beat stable and no data loss; exactly one extra poll follows.
- rst_n_i asserted low mid-REQ → cyc/stb/tvalid drop with no clock edge, busy_o = 0. After release, the first poll restarts at i = 0.
- INTERVAL = 100, no start_i → poll begins every 100 cycles; busy_o rises 1 cycle after the timer reaches 0.
